// File: rtl/obstacle_mover.sv
// Multi-channel obstacle mover: a shared movement-tick prescaler drives N_OBJ
// independent channels that spawn at a fixed point, slide left and optionally fall.
//
// state    | meaning
// S_IDLE   | channel off screen, position held at 0, waits for a spawn request
// S_ACTIVE | channel on screen, moves on each tick, despawns when x < speed
module obstacle_mover #(
   parameter int N_OBJ    = 4,
   parameter int XW       = 10,
   parameter int YW       = 10,
   parameter int SW       = 3,
   parameter int TICK_DIV = 251250,
   parameter int SPAWN_X  = 639,
   parameter int SPAWN_Y  = 0,
   parameter int Y_MAX    = 479
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                halt,
   input  logic [N_OBJ-1:0]    spawn,
   input  logic [N_OBJ-1:0]    diag,
   input  logic [SW-1:0]       speed,
   output logic                tick,
   output logic [N_OBJ-1:0]    active,
   output logic [N_OBJ-1:0]    despawned,
   output logic [N_OBJ*XW-1:0] xpos,
   output logic [N_OBJ*YW-1:0] ypos
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   logic [CW-1:0] r_cnt;
   logic          w_tick;
   logic [XW-1:0] w_spd_x;
   logic [YW:0]   w_spd_y;

   assign w_tick  = !halt && (r_cnt == CNT_LAST);
   assign tick    = w_tick;
   assign w_spd_x = {{(XW-SW){1'b0}}, speed};
   assign w_spd_y = {{(YW+1-SW){1'b0}}, speed};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (!halt) begin
         r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
      end
   end

   for (genvar i = 0; i < N_OBJ; i++) begin : g_ch
      state_t        r_state, w_state_nxt;
      logic [XW-1:0] r_x, w_x_nxt;
      logic [YW-1:0] r_y, w_y_nxt;
      logic          r_diag, w_diag_nxt;
      logic          r_desp, w_desp_nxt;
      logic [YW:0]   w_y_sum;

      // One bit wider than y so the saturation compare never sees a wrap.
      assign w_y_sum = {1'b0, r_y} + w_spd_y;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_diag  <= 1'b0;
            r_desp  <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_diag  <= w_diag_nxt;
            r_desp  <= w_desp_nxt;
         end
      end

      always_comb begin
         w_state_nxt = r_state;
         w_x_nxt     = r_x;
         w_y_nxt     = r_y;
         w_diag_nxt  = r_diag;
         w_desp_nxt  = 1'b0;
         case (r_state)
            S_IDLE: begin
               // A request landing on the despawn pulse is dropped; a fresh one is needed.
               if (spawn[i] && !halt && !r_desp) begin
                  w_state_nxt = S_ACTIVE;
                  w_x_nxt     = XW'(SPAWN_X);
                  w_y_nxt     = YW'(SPAWN_Y);
                  w_diag_nxt  = diag[i];
               end
            end
            S_ACTIVE: begin
               if (w_tick) begin
                  if (r_x >= w_spd_x) begin
                     w_x_nxt = r_x - w_spd_x;
                     if (r_diag) begin
                        w_y_nxt = (w_y_sum > (YW+1)'(Y_MAX)) ? YW'(Y_MAX) : w_y_sum[YW-1:0];
                     end
                  end else begin
                     w_state_nxt = S_IDLE;
                     w_x_nxt     = '0;
                     w_y_nxt     = '0;
                     w_desp_nxt  = 1'b1;
                  end
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_x_nxt     = '0;
               w_y_nxt     = '0;
            end
         endcase
      end

      assign active[i]             = (r_state == S_ACTIVE);
      assign despawned[i]          = r_desp;
      assign xpos[i*XW +: XW]      = r_x;
      assign ypos[i*YW +: YW]      = r_y;
   end

endmodule

// File: tb/tb_obstacle_mover.sv
// Bench for obstacle_mover: hand table for the opening sequence, directed corner
// sequences and a random run, all checked against a per-channel arithmetic model.
module tb_obstacle_mover;
   localparam int N  = 4;
   localparam int XW = 10;
   localparam int YW = 10;
   localparam int SW = 3;
   localparam int TD = 4;
   localparam int SX = 639;
   localparam int SY = 470;
   localparam int YM = 479;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              halt = 1'b0;
   logic [N-1:0]      spawn = '0;
   logic [N-1:0]      diag = '0;
   logic [SW-1:0]     speed = '0;
   logic              tick;
   logic [N-1:0]      active;
   logic [N-1:0]      despawned;
   logic [N*XW-1:0]   xpos;
   logic [N*YW-1:0]   ypos;

   always #5 clk = ~clk;

   obstacle_mover #(
      .N_OBJ(N), .XW(XW), .YW(YW), .SW(SW), .TICK_DIV(TD),
      .SPAWN_X(SX), .SPAWN_Y(SY), .Y_MAX(YM)
   ) dut (
      .clk(clk), .reset(reset), .halt(halt), .spawn(spawn), .diag(diag),
      .speed(speed), .tick(tick), .active(active), .despawned(despawned),
      .xpos(xpos), .ypos(ypos)
   );

   int total = 0;
   int bad = 0;

   int m_cnt;
   int m_act[N];
   int m_x[N];
   int m_y[N];
   int m_dg[N];
   int m_desp[N];
   bit m_last_tick;

   typedef struct {
      logic       h;
      logic [3:0] sp;
      logic [3:0] dg;
      logic [2:0] spd;
      logic       exp_tick;
      logic [3:0] exp_act;
      int         exp_x0;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_cnt = 0;
      m_last_tick = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dg[i] = 0; m_desp[i] = 0;
      end
   endfunction

   // One clock: check the combinational tick, advance the model, clock, check registers.
   task automatic cyc();
      bit tk;
      int s;
      logic [N*XW-1:0] ex;
      logic [N*YW-1:0] ey;
      logic [N-1:0]    ea, ed;
      #1;
      tk = (!halt && m_cnt == TD-1);
      chk("tick", tick, tk);
      s = int'(speed);
      for (int i = 0; i < N; i++) begin
         if (m_act[i] == 0) begin
            if (spawn[i] && !halt && m_desp[i] == 0) begin
               m_act[i] = 1; m_x[i] = SX; m_y[i] = SY; m_dg[i] = int'(diag[i]);
            end
            m_desp[i] = 0;
         end else begin
            m_desp[i] = 0;
            if (tk && m_x[i] < s) begin
               m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_desp[i] = 1;
            end else if (tk) begin
               m_x[i] = m_x[i] - s;
               if (m_dg[i] != 0) m_y[i] = (m_y[i] + s > YM) ? YM : m_y[i] + s;
            end
         end
      end
      if (!halt) m_cnt = (m_cnt + 1) % TD;
      m_last_tick = tk;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         ex[i*XW +: XW] = m_x[i][XW-1:0];
         ey[i*YW +: YW] = m_y[i][YW-1:0];
         ea[i] = (m_act[i] != 0);
         ed[i] = (m_desp[i] != 0);
      end
      chk("active", active, ea);
      chk("despawned", despawned, ed);
      chk("xpos", xpos, ex);
      chk("ypos", ypos, ey);
   endtask

   task automatic do_reset();
      reset = 1'b0; halt = 1'b0; spawn = '0; diag = '0; speed = '0;
      @(posedge clk);
      @(posedge clk);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_tick();
      bit got;
      got = 1'b0;
      for (int c = 0; c < 2*TD && !got; c++) begin
         cyc();
         if (m_last_tick) got = 1'b1;
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL wait_tick timeout at %0t", $time);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int ey[4];
      bit saw_zero, got;
      int first;

      tbl[0]  = '{1'b0, 4'b0001, 4'b0000, 3'd3, 1'b0, 4'b0001, 639};
      tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 3'd3, 1'b0, 4'b0001, 639};
      tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 3'd3, 1'b0, 4'b0001, 639};
      tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 3'd3, 1'b1, 4'b0001, 636};
      tbl[4]  = '{1'b0, 4'b0001, 4'b0001, 3'd3, 1'b0, 4'b0001, 636};
      tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 3'd3, 1'b0, 4'b0001, 636};
      tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 3'd3, 1'b0, 4'b0001, 636};
      tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 3'd3, 1'b1, 4'b0001, 633};
      tbl[8]  = '{1'b1, 4'b0000, 4'b0000, 3'd3, 1'b0, 4'b0001, 633};
      tbl[9]  = '{1'b1, 4'b0100, 4'b0000, 3'd3, 1'b0, 4'b0001, 633};
      tbl[10] = '{1'b1, 4'b0000, 4'b0000, 3'd3, 1'b0, 4'b0001, 633};
      tbl[11] = '{1'b0, 4'b0000, 4'b0000, 3'd3, 1'b0, 4'b0001, 633};
      tbl[12] = '{1'b0, 4'b0000, 4'b0000, 3'd3, 1'b0, 4'b0001, 633};
      tbl[13] = '{1'b0, 4'b0000, 4'b0000, 3'd3, 1'b0, 4'b0001, 633};
      tbl[14] = '{1'b0, 4'b0000, 4'b0000, 3'd3, 1'b1, 4'b0001, 630};

      do_reset();
      #1;
      chk("rst_active", active, 0);
      chk("rst_xpos", xpos, 0);
      chk("rst_tick", tick, 0);

      for (int k = 0; k < 15; k++) begin
         halt = tbl[k].h; spawn = tbl[k].sp; diag = tbl[k].dg; speed = tbl[k].spd;
         #1;
         chk("tbl_tick", tick, tbl[k].exp_tick);
         cyc();
         chk("tbl_active", active, tbl[k].exp_act);
         chk("tbl_x0", xpos[XW-1:0], tbl[k].exp_x0);
      end

      // Diagonal fall saturates at Y_MAX; diag changes after spawn are ignored.
      do_reset();
      ey[0] = 474; ey[1] = 478; ey[2] = 479; ey[3] = 479;
      spawn = 4'b0010; diag = 4'b0010; speed = 3'd4;
      cyc();
      spawn = '0; diag = '0;
      for (int t = 0; t < 4; t++) begin
         wait_tick();
         chk("diag_y1", ypos[2*YW-1:YW], ey[t]);
         chk("diag_x1", xpos[2*XW-1:XW], SX - 4*(t+1));
      end

      // Exact walk to x=0 then despawn; a spawn on the despawn pulse is dropped.
      do_reset();
      speed = 3'd3; spawn = 4'b0001;
      cyc();
      spawn = '0;
      saw_zero = 1'b0; got = 1'b0;
      for (int c = 0; c < 1200 && !got; c++) begin
         cyc();
         if (active[0] && xpos[XW-1:0] == 0) saw_zero = 1'b1;
         if (m_desp[0] != 0) got = 1'b1;
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL despawn timeout at %0t", $time);
      end
      chk("desp_saw_x0", saw_zero, 1);
      chk("desp_pulse", despawned[0], 1);
      chk("desp_x0", xpos[XW-1:0], 0);
      spawn = 4'b0001;
      cyc();
      spawn = '0;
      chk("spawn_on_desp", active[0], 0);
      chk("desp_one_cycle", despawned[0], 0);

      // Spawn coinciding with a tick loads SPAWN_X with no decrement.
      for (int c = 0; c < TD && m_cnt != TD-1; c++) cyc();
      spawn = 4'b1000;
      cyc();
      spawn = '0;
      chk("spawn_on_tick_x3", xpos[4*XW-1:3*XW], SX);

      // Long halt with a spawn request in the middle.
      spawn = 4'b0011; diag = 4'b0001;
      cyc();
      spawn = '0;
      halt = 1'b1;
      for (int c = 0; c < 20; c++) begin
         spawn = (c == 10) ? 4'b0100 : 4'b0000;
         cyc();
      end
      spawn = '0; halt = 1'b0;
      chk("halt_ch2_idle", active[2], 0);
      for (int c = 0; c < 8; c++) cyc();

      // Asynchronous reset with all channels active.
      spawn = 4'b1111; diag = 4'b0101;
      cyc();
      spawn = '0;
      for (int c = 0; c < 6; c++) cyc();
      chk("all_active", active, 4'b1111);
      #3;
      reset = 1'b0;
      #1;
      chk("arst_active", active, 0);
      chk("arst_xpos", xpos, 0);
      chk("arst_ypos", ypos, 0);
      chk("arst_tick", tick, 0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      first = 0;
      for (int c = 1; c <= 2*TD; c++) begin
         cyc();
         if (first == 0 && m_last_tick) first = c;
      end
      chk("first_tick_cycle", first, TD);

      // Random traffic against the model.
      speed = 3'($urandom);
      for (int k = 0; k < 3000; k++) begin
         halt  = ($urandom_range(9) == 0);
         spawn = ($urandom_range(3) == 0) ? N'($urandom) : '0;
         diag  = N'($urandom);
         if ($urandom_range(49) == 0) speed = 3'($urandom);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
